// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR AP controller: FSM state encoding,
// ring-buffer geometry and AP status-register bit positions.
package fir_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_IN,
      S_RUN,
      S_OUT,
      S_DONE
   } fir_state_e;

   localparam int          TAP_NUM   = 11;
   localparam int          ADDR_STEP = 4;
   localparam logic [11:0] LAST_ADDR = 12'h028;

   localparam int AP_START_BIT = 0;
   localparam int AP_DONE_BIT  = 1;
   localparam int AP_IDLE_BIT  = 2;

   // Byte address of the final ring slot for a given tap count.
   function automatic int last_addr_of(input int taps);
      return ADDR_STEP * (taps - 1);
   endfunction

endpackage

// File: rtl/fir_ap_ctrl_if.sv
// Bundle of config, AXI-Stream, data-RAM and MAC-engine signals around fir_ap_ctrl.
// master = controller view, slave = environment (regs, streams, RAM, engine) view.
interface fir_ap_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              cfg_start;
   logic [31:0]       cfg_len;
   logic              sts_rd;
   logic              ap_start;
   logic              ap_done;
   logic              ap_idle;

   logic              ss_tvalid;
   logic [DATA_W-1:0] ss_tdata;
   logic              ss_tlast;
   logic              ss_tready;

   logic              sm_tvalid;
   logic [DATA_W-1:0] sm_tdata;
   logic              sm_tlast;
   logic              sm_tready;

   logic              dram_we;
   logic [ADDR_W-1:0] dram_addr;
   logic [DATA_W-1:0] dram_wdata;

   logic              eng_start;
   logic [ADDR_W-1:0] eng_start_addr;
   logic              eng_done;
   logic [DATA_W-1:0] eng_result;

   logic              err_tlast;

   modport master (
      input  cfg_start, cfg_len, sts_rd,
      input  ss_tvalid, ss_tdata, ss_tlast,
      input  sm_tready,
      input  eng_done, eng_result,
      output ap_start, ap_done, ap_idle,
      output ss_tready,
      output sm_tvalid, sm_tdata, sm_tlast,
      output dram_we, dram_addr, dram_wdata,
      output eng_start, eng_start_addr,
      output err_tlast
   );

   modport slave (
      output cfg_start, cfg_len, sts_rd,
      output ss_tvalid, ss_tdata, ss_tlast,
      output sm_tready,
      output eng_done, eng_result,
      input  ap_start, ap_done, ap_idle,
      input  ss_tready,
      input  sm_tvalid, sm_tdata, sm_tlast,
      input  dram_we, dram_addr, dram_wdata,
      input  eng_start, eng_start_addr,
      input  err_tlast
   );
endinterface

// File: rtl/fir_ring_ptr.sv
// Wrapping byte-address counter over the tap ring: 0, 4, ... last slot, then back to 0.
module fir_ring_ptr
   import fir_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int TAPS   = TAP_NUM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr,
   output logic              at_last
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(last_addr_of(TAPS));
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   assign at_last = (addr == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         addr <= '0;
      else if (adv)
         addr <= at_last ? '0 : addr + STEP;
   end
endmodule

// File: rtl/fir_ap_ctrl.sv
// FIR core sequencer: ap_start/ap_done/ap_idle, data-RAM zero fill, ring-buffer sample
// writes, per-sample engine launch and result streaming. Optional macro:
// FIR_CTRL_TLAST_CHK_EN enables the sticky ss_tlast mismatch flag err_tlast.
module fir_ap_ctrl
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pTAP_NUM    = TAP_NUM
) (
   input logic          axis_clk,
   input logic          axis_rst,
   fir_ap_ctrl_if.master bus
);
   fir_state_e             state;
   logic [31:0]            len, cnt, cnt_nxt;
   logic [pADDR_WIDTH-1:0] clr_addr, wr_addr;
   logic                   clr_last, wr_last;
   logic                   start_acc, in_hs, out_hs, is_last, set_done;

   assign cnt_nxt   = cnt + 32'd1;
   assign is_last   = (cnt_nxt == len);
   assign start_acc = (state == S_IDLE) && bus.cfg_start;
   assign in_hs     = (state == S_WAIT_IN) && bus.ss_tvalid;
   assign out_hs    = (state == S_OUT) && bus.sm_tready;
   assign set_done  = ((state == S_CLEAR) && clr_last && (len == 32'd0)) || (out_hs && is_last);

   assign bus.ss_tready = (state == S_WAIT_IN);

   fir_ring_ptr #(.ADDR_W(pADDR_WIDTH), .TAPS(pTAP_NUM)) u_clr_ptr (
      .clk(axis_clk), .rst(axis_rst), .clr(start_acc), .adv(state == S_CLEAR),
      .addr(clr_addr), .at_last(clr_last)
   );

   fir_ring_ptr #(.ADDR_W(pADDR_WIDTH), .TAPS(pTAP_NUM)) u_wr_ptr (
      .clk(axis_clk), .rst(axis_rst), .clr(start_acc), .adv(out_hs),
      .addr(wr_addr), .at_last(wr_last)
   );

   // The sample write must land in the same cycle as the input handshake, so the
   // RAM port is a pure decode of state and stream inputs.
   always_comb begin
      bus.dram_we    = 1'b0;
      bus.dram_addr  = '0;
      bus.dram_wdata = '0;
      if (state == S_CLEAR) begin
         bus.dram_we   = 1'b1;
         bus.dram_addr = clr_addr;
      end else if (state == S_WAIT_IN) begin
         bus.dram_we    = bus.ss_tvalid;
         bus.dram_addr  = wr_addr;
         bus.dram_wdata = bus.ss_tdata;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state              <= S_IDLE;
         len                <= '0;
         cnt                <= '0;
         bus.ap_start       <= 1'b0;
         bus.ap_done        <= 1'b0;
         bus.ap_idle        <= 1'b1;
         bus.sm_tvalid      <= 1'b0;
         bus.sm_tdata       <= '0;
         bus.sm_tlast       <= 1'b0;
         bus.eng_start      <= 1'b0;
         bus.eng_start_addr <= '0;
      end else begin
         bus.eng_start <= 1'b0;
         case (state)
            S_IDLE: if (bus.cfg_start) begin
               state        <= S_CLEAR;
               len          <= bus.cfg_len;
               cnt          <= '0;
               bus.ap_start <= 1'b1;
               bus.ap_idle  <= 1'b0;
            end
            S_CLEAR: if (clr_last)
               state <= (len == 32'd0) ? S_DONE : S_WAIT_IN;
            S_WAIT_IN: if (in_hs) begin
               state              <= S_RUN;
               bus.ap_start       <= 1'b0;
               bus.eng_start      <= 1'b1;
               bus.eng_start_addr <= wr_addr;
            end
            S_RUN: if (bus.eng_done) begin
               state         <= S_OUT;
               bus.sm_tvalid <= 1'b1;
               bus.sm_tdata  <= bus.eng_result;
               bus.sm_tlast  <= is_last;
            end
            S_OUT: if (bus.sm_tready) begin
               state         <= is_last ? S_DONE : S_WAIT_IN;
               cnt           <= cnt_nxt;
               bus.sm_tvalid <= 1'b0;
               bus.sm_tlast  <= 1'b0;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // Entering DONE beats a coincident status read.
         if (set_done) begin
            bus.ap_done  <= 1'b1;
            bus.ap_idle  <= 1'b1;
            bus.ap_start <= 1'b0;
         end else if (bus.sts_rd || start_acc) begin
            bus.ap_done <= 1'b0;
         end
      end
   end

`ifdef FIR_CTRL_TLAST_CHK_EN
   always_ff @(posedge axis_clk) begin
      if (axis_rst || start_acc)
         bus.err_tlast <= 1'b0;
      else if (in_hs && (bus.ss_tlast != is_last))
         bus.err_tlast <= 1'b1;
   end
`else
   logic unused_tlast;
   assign unused_tlast  = bus.ss_tlast;
   assign bus.err_tlast = 1'b0;
`endif

   logic unused_wr_last;
   assign unused_wr_last = wr_last;

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Self-checking bench for fir_ap_ctrl: table of frame runs plus hand sequences for
// status-read clear and reset during RUN.
module tb_fir_ap_ctrl;
`ifdef FIR_CTRL_TLAST_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nchk = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   fir_ap_ctrl_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   fir_ap_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pTAP_NUM(11)) dut (
      .axis_clk(clk), .axis_rst(rst), .bus(bus)
   );

   typedef struct {
      int          len;
      int          stall;
      int          tlast_beat;
      bit          poke;
      logic [11:0] exp_last_addr;
      int          exp_nout;
      bit          exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] samp(input int len, input int k);
      return 32'h100 + 32'(k * 7) + 32'(len * 256);
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ap_idle"},   bus.ap_idle,   1);
      chk({tag, "_ap_start"},  bus.ap_start,  0);
      chk({tag, "_ap_done"},   bus.ap_done,   0);
      chk({tag, "_ss_tready"}, bus.ss_tready, 0);
      chk({tag, "_sm_tvalid"}, bus.sm_tvalid, 0);
      chk({tag, "_sm_tdata"},  bus.sm_tdata,  0);
      chk({tag, "_dram_we"},   bus.dram_we,   0);
      chk({tag, "_eng_start"}, bus.eng_start, 0);
      chk({tag, "_err_tlast"}, bus.err_tlast, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int          nclr = 0, nin = 0, nout = 0, cd = 0, cyc = 0;
      int          stall_left = v.stall;
      bit          done = 0, poke_pend = 0, poked = 0;
      logic [31:0] held = '0;
      logic [31:0] last_sample = '0;
      logic [11:0] last_addr = 12'hFFF;
      @(negedge clk);
      bus.cfg_len   = v.len;
      bus.cfg_start = 1'b1;
      while (!done && cyc < 300 + 20 * v.len) begin
         @(negedge clk);
         cyc++;
         bus.cfg_start = 1'b0;
         if (poke_pend) begin
            bus.cfg_start = 1'b1;
            bus.cfg_len   = 99;
            poke_pend     = 0;
            poked         = 1;
         end
         if (cyc == 1) begin
            chk("start_ap_start", bus.ap_start, 1);
            chk("start_ap_idle",  bus.ap_idle,  0);
            chk("start_ap_done",  bus.ap_done,  0);
         end
         bus.eng_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.eng_done   = 1'b1;
               bus.eng_result = last_sample * 3 + 1;
            end
         end
         bus.sm_tready = 1'b1;
         if (bus.sm_tvalid) begin
            if (stall_left > 0) begin
               if (stall_left == v.stall) held = bus.sm_tdata;
               else chk("stall_hold", bus.sm_tdata, held);
               chk("stall_ss_tready", bus.ss_tready, 0);
               bus.sm_tready = 1'b0;
               stall_left--;
            end else begin
               chk("sm_tdata", bus.sm_tdata, samp(v.len, nout) * 3 + 1);
               chk("sm_tlast", bus.sm_tlast, 32'(nout == v.len - 1));
               nout++;
            end
         end
         bus.ss_tvalid = (nin < v.len);
         bus.ss_tdata  = samp(v.len, nin);
         bus.ss_tlast  = (nin + 1 == v.tlast_beat);
         #1;
         if (bus.eng_start) begin
            last_addr = bus.eng_start_addr;
            chk("eng_start_addr", bus.eng_start_addr, 32'(4 * ((nin - 1) % 11)));
            cd = 3;
            if (v.poke && !poked) poke_pend = 1;
         end
         if (bus.dram_we) begin
            if (!bus.ss_tready) begin
               chk("clr_addr",  bus.dram_addr,  32'(4 * nclr));
               chk("clr_wdata", bus.dram_wdata, 0);
               nclr++;
            end else begin
               chk("wr_addr", bus.dram_addr,  32'(4 * (nin % 11)));
               chk("wr_data", bus.dram_wdata, samp(v.len, nin));
            end
         end
         if (bus.ss_tready && bus.ss_tvalid) begin
            last_sample = samp(v.len, nin);
            nin++;
         end
         if (bus.ap_done) begin
            done = 1;
            chk("done_ap_idle",   bus.ap_idle,   1);
            chk("done_sm_tvalid", bus.sm_tvalid, 0);
         end
      end
      bus.ss_tvalid = 1'b0;
      bus.ss_tlast  = 1'b0;
      chk("run_timeout", 32'(done), 1);
      chk("clr_count",   nclr, 11);
      chk("out_count",   nout, v.exp_nout);
      chk("last_addr",   last_addr, v.exp_last_addr);
      chk("err_tlast",   bus.err_tlast, 32'(v.exp_err));
      chk("end_ap_start", bus.ap_start, 0);
   endtask

   initial begin
      bus.cfg_start  = 1'b0;
      bus.cfg_len    = '0;
      bus.sts_rd     = 1'b0;
      bus.ss_tvalid  = 1'b0;
      bus.ss_tdata   = '0;
      bus.ss_tlast   = 1'b0;
      bus.sm_tready  = 1'b1;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;

      //         len stall tlast poke last_addr nout err
      vecs[0] = '{3,  0, 3,  0, 12'h008, 3,  0};
      vecs[1] = '{13, 0, 13, 0, 12'h004, 13, 0};
      vecs[2] = '{1,  5, 1,  0, 12'h000, 1,  0};
      vecs[3] = '{0,  0, 0,  0, 12'hFFF, 0,  0};
      vecs[4] = '{4,  0, 2,  0, 12'h00C, 4,  CHK};
      vecs[5] = '{2,  2, 2,  1, 12'h004, 2,  0};
      vecs[6] = '{12, 0, 12, 0, 12'h000, 12, 0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_state("reset");

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // ap_done stays set in IDLE until the status read
      @(negedge clk);
      chk("done_sticky", bus.ap_done, 1);
      bus.sts_rd = 1'b1;
      @(negedge clk);
      bus.sts_rd = 1'b0;
      chk("sts_rd_clear", bus.ap_done, 0);

      // Reset while the engine is running
      @(negedge clk);
      bus.cfg_len   = 5;
      bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
      bus.ss_tvalid = 1'b1;
      bus.ss_tdata  = 32'hABCD;
      begin
         int  w = 0;
         bit  seen = 0;
         while (!seen && w < 100) begin
            @(negedge clk);
            #1;
            w++;
            if (bus.eng_start) seen = 1;
         end
         chk("rst_reach_run", 32'(seen), 1);
      end
      bus.ss_tvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_state("rst_mid_run");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
